// File: rtl/status_capture_pkg.sv
// Shared definitions for the status capture front end: walker status codes
// and the commit counter width with its saturating increment.
package status_capture_pkg;

  typedef enum logic [1:0] {
    ST_FIT       = 2'b00,
    ST_ATTACKED  = 2'b01,
    ST_HURT      = 2'b10,
    ST_NO_CHANGE = 2'b11
  } status_code_e;

  localparam int unsigned STATUS_W = 16;
  localparam int unsigned COUNT_W  = 4;
  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (v == COUNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/status_capture_btn_debounce.sv
// Push-button front end: 2-flop synchroniser, counting debouncer and a
// registered rising-edge detector on the debounced level.
module btn_debounce
  import status_capture_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic rise
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             deb;
  logic             deb_d;
  logic [CNT_W-1:0] cnt;

  // Any sample agreeing with the current level restarts the run, so only an
  // unbroken run of DEBOUNCE_CYCLES differing samples flips the level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      deb   <= 1'b0;
      deb_d <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      deb_d <= deb;
      if (sync2 == deb) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        deb <= ~deb;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign level = deb;
  assign rise  = deb & ~deb_d;

endmodule

// File: rtl/status_capture.sv
// Switch/button front end for the flag-city walker: latches the synchronised
// switches on a debounced load press and withdraws them on a clear press.
module status_capture
  import status_capture_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [STATUS_W-1:0] sw,
  input  logic                btn_load,
  input  logic                btn_clear,
  output logic [STATUS_W-1:0] status,
  output logic                status_valid,
  output logic                load_pulse,
  output logic [COUNT_W-1:0]  load_count
);

  localparam logic STATE_EMPTY = 1'b0;
  localparam logic STATE_HELD  = 1'b1;

  logic                state;
  logic [STATUS_W-1:0] sw_s1;
  logic [STATUS_W-1:0] sw_s2;
  logic                load_level;
  logic                load_rise;
  logic                clear_level;
  logic                clear_rise;
  logic                unused_levels;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_load),
    .level   (load_level),
    .rise    (load_rise)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_clear),
    .level   (clear_level),
    .rise    (clear_rise)
  );

  assign unused_levels = load_level ^ clear_level;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
    end else begin
      sw_s1 <= sw;
      sw_s2 <= sw_s1;
    end
  end

  // Clear is tested first so a coincident load is discarded.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= STATE_EMPTY;
      status       <= '0;
      status_valid <= 1'b0;
      load_pulse   <= 1'b0;
      load_count   <= '0;
    end else begin
      load_pulse <= 1'b0;
      if (clear_rise) begin
        state        <= STATE_EMPTY;
        status       <= '0;
        status_valid <= 1'b0;
        load_count   <= '0;
      end else if (load_rise) begin
        status     <= sw_s2;
        load_pulse <= 1'b1;
        case (state)
          STATE_EMPTY: begin
            status_valid <= 1'b1;
            load_count   <= COUNT_W'(1);
            state        <= STATE_HELD;
          end
          default: begin
            load_count <= sat_inc(load_count);
            state      <= STATE_HELD;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_status_capture.sv
// Self-checking bench for status_capture: directed scenarios plus randomized
// button/switch traffic compared against a window-based behavioural model.
module tb_status_capture;

  localparam int unsigned DC = 4;
  localparam logic [31:0] MASK = (32'd1 << DC) - 32'd1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] sw = '0;
  logic        btn_load = 1'b0;
  logic        btn_clear = 1'b0;
  logic [15:0] status;
  logic        status_valid;
  logic        load_pulse;
  logic [3:0]  load_count;

  status_capture #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk          (clk),
    .rst          (rst),
    .sw           (sw),
    .btn_load     (btn_load),
    .btn_clear    (btn_clear),
    .status       (status),
    .status_valid (status_valid),
    .load_pulse   (load_pulse),
    .load_count   (load_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: raw inputs reach the debouncer two edges late; a level flips once
  // the last DC samples all disagree with it; a commit follows one edge later.
  logic [1:0]  r_l, r_c;
  logic [15:0] sw_a, sw_b;
  logic [31:0] h_l, h_c;
  bit          d_l, d_c, dd_l, dd_c;
  logic [15:0] m_status;
  bit          m_valid, m_pulse;
  int          m_count;

  function automatic void m_reset();
    r_l = '0; r_c = '0; sw_a = '0; sw_b = '0;
    h_l = '0; h_c = '0;
    d_l = 0; d_c = 0; dd_l = 0; dd_c = 0;
    m_status = '0; m_valid = 0; m_pulse = 0; m_count = 0;
  endfunction

  function automatic void deb_step(inout bit d, inout bit dd, inout logic [31:0] h, input bit s);
    dd = d;
    h = {h[30:0], s};
    if ((h & MASK) == (d ? 32'h0 : MASK)) d = ~d;
  endfunction

  function automatic void model_edge(input bit ld, input bit cl, input logic [15:0] s);
    bit rise_l, rise_c;
    rise_l = d_l & ~dd_l;
    rise_c = d_c & ~dd_c;
    m_pulse = 0;
    if (rise_c) begin
      m_status = '0; m_valid = 0; m_count = 0;
    end else if (rise_l) begin
      m_status = sw_b;
      m_pulse  = 1;
      m_count  = m_valid ? ((m_count < 15) ? m_count + 1 : 15) : 1;
      m_valid  = 1;
    end
    deb_step(d_l, dd_l, h_l, r_l[1]);
    deb_step(d_c, dd_c, h_c, r_c[1]);
    r_l  = {r_l[0], ld};
    r_c  = {r_c[0], cl};
    sw_b = sw_a;
    sw_a = s;
  endfunction

  task automatic compare_all();
    chk("status", 32'(status), 32'(m_status));
    chk("status_valid", 32'(status_valid), 32'(m_valid));
    chk("load_pulse", 32'(load_pulse), 32'(m_pulse));
    chk("load_count", 32'(load_count), 32'(m_count));
  endtask

  // Called just after a falling edge: drive, let one rising edge pass, check.
  task automatic cyc(input bit ld, input bit cl, input logic [15:0] s);
    btn_load = ld; btn_clear = cl; sw = s;
    @(posedge clk);
    if (rst) model_edge(ld, cl, s);
    @(negedge clk);
    compare_all();
  endtask

  task automatic assert_reset();
    rst = 1'b0;
    m_reset();
    #1;
    compare_all();
  endtask

  initial begin
    m_reset();
    repeat (2) @(negedge clk);
    compare_all();
    chk("reset_status", 32'(status), 32'h0);
    rst = 1'b1;

    // Basic load: commit lands on the seventh edge after the press (edge 6).
    for (int i = 0; i < 6; i++) cyc(1, 0, 16'h5A3C);
    chk("basic_early_pulse", 32'(load_pulse), 32'h0);
    cyc(1, 0, 16'h5A3C);
    chk("basic_status", 32'(status), 32'h5A3C);
    chk("basic_valid", 32'(status_valid), 32'h1);
    chk("basic_count", 32'(load_count), 32'h1);
    chk("basic_pulse", 32'(load_pulse), 32'h1);
    cyc(1, 0, 16'h5A3C);
    chk("basic_pulse_one_cycle", 32'(load_pulse), 32'h0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 16'hFFFF);
    chk("latched_word", 32'(status), 32'h5A3C);

    // Count saturation across 16 clean presses.
    for (int p = 0; p < 16; p++) begin
      for (int i = 0; i < 6; i++) cyc(1, 0, 16'(p));
      for (int i = 0; i < 8; i++) cyc(0, 0, 16'hFFFF);
    end
    chk("count_saturated", 32'(load_count), 32'hF);
    chk("last_word", 32'(status), 32'hF);

    // Simultaneous load and clear while held: clear wins.
    for (int i = 0; i < 10; i++) cyc(1, 1, 16'h1234);
    chk("simul_status", 32'(status), 32'h0);
    chk("simul_valid", 32'(status_valid), 32'h0);
    chk("simul_count", 32'(load_count), 32'h0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 16'h1234);

    // Bounce shorter than the debounce window never commits.
    for (int i = 0; i < 3; i++) cyc(1, 0, 16'hBEEF);
    cyc(0, 0, 16'hBEEF);
    for (int i = 0; i < 3; i++) cyc(1, 0, 16'hBEEF);
    for (int i = 0; i < 10; i++) cyc(0, 0, 16'hBEEF);
    chk("bounce_valid", 32'(status_valid), 32'h0);
    chk("bounce_status", 32'(status), 32'h0);

    // Reset mid-press with the button still held afterwards.
    for (int i = 0; i < 3; i++) cyc(1, 0, 16'hC0DE);
    assert_reset();
    for (int i = 0; i < 2; i++) cyc(1, 0, 16'hC0DE);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) cyc(1, 0, 16'hC0DE);
    chk("rst_no_early_commit", 32'(status_valid), 32'h0);
    cyc(1, 0, 16'hC0DE);
    chk("rst_commit_pulse", 32'(load_pulse), 32'h1);
    chk("rst_commit_status", 32'(status), 32'hC0DE);
    chk("rst_commit_count", 32'(load_count), 32'h1);
    for (int i = 0; i < 8; i++) cyc(0, 0, 16'h0);

    // Randomized traffic: level segments of random length, occasional resets.
    for (int seg = 0; seg < 300; seg++) begin
      bit ld, cl;
      int len;
      ld  = ($urandom_range(0, 1) == 1);
      cl  = ($urandom_range(0, 5) == 0);
      len = $urandom_range(1, 10);
      if ($urandom_range(0, 60) == 0) begin
        assert_reset();
        cyc(ld, cl, 16'($urandom));
        rst = 1'b1;
      end
      for (int i = 0; i < len; i++) cyc(ld, cl, 16'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
